// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce and a
// two-digit BCD accumulator.
//
// One row is driven low at a time, and the synchronized columns are sampled
// once per scan tick. A press must stay stable for DEBOUNCE_SCANS ticks
// (the detect tick counts as the first) before it is accepted. A release must
// read all-high for DEBOUNCE_SCANS consecutive ticks before scanning resumes.
// Each accepted key gives a one-cycle key_valid. key_code and bcd_out already
// show the new values in that same cycle.
//
// Optional build macro: KEY_REPEAT_EN. When it is defined, a held key
// re-emits its event every REPEAT_SCANS ticks.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     keypad columns, active-low, asynchronous to clk
//   row_out    keypad row drive, active-low one-hot
//   key_valid  one-cycle pulse per accepted key event
//   key_code   hex code of the last accepted key, held between events
//   bcd_out    [7:4] tens digit, [3:0] units digit

`timescale 1ns/1ps

module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] bcd_out
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_SCANS - 1);
`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_SCANS - 1);
`endif

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  // Position of the single zero in an active-low one-hot nibble.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    unique case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Column synchronizer. It idles high because the columns are pulled up.
  logic [3:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // Scan-tick prescaler
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  assign tick    = (presc_q == PrescLast);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Column classification
  logic col_all_high, col_one_low;

  always_comb begin
    col_one_low = 1'b0;
    unique case (col_sync_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: col_one_low = 1'b1;
      default:                            col_one_low = 1'b0;
    endcase
  end

  assign col_all_high = &col_sync_q;

  // FSM and datapath state
  state_e          state_q, state_d;
  logic [3:0]      row_q, row_d, row_rot;
  logic [3:0]      col_lat_q, col_lat_d;
  logic [DebW-1:0] deb_q, deb_d;
  logic [DebW-1:0] rel_q, rel_d;
  logic            deb_done;
  logic            emit;
`ifdef KEY_REPEAT_EN
  logic [RepW-1:0] rep_q, rep_d;
`endif

  logic       key_valid_q, key_valid_d;
  logic [3:0] key_code_q, key_code_d;
  logic [7:0] bcd_q, bcd_d;
  logic [3:0] ev_code;

  assign row_rot = {row_q[2:0], row_q[3]};
  // The detect tick in StScan counts as the first stable tick. So the press
  // is accepted when the match count reaches DEBOUNCE_SCANS-1.
  assign deb_done = (32'(deb_q) + 32'd1) >= (DEBOUNCE_SCANS - 32'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      state_q     <= StScan;
      row_q       <= 4'b1110;
      col_lat_q   <= 4'hF;
      deb_q       <= '0;
      rel_q       <= '0;
`ifdef KEY_REPEAT_EN
      rep_q       <= '0;
`endif
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      bcd_q       <= 8'h00;
    end else begin
      presc_q     <= presc_d;
      state_q     <= state_d;
      row_q       <= row_d;
      col_lat_q   <= col_lat_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
`ifdef KEY_REPEAT_EN
      rep_q       <= rep_d;
`endif
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      bcd_q       <= bcd_d;
    end
  end

  // Next-state logic. Every decision waits for a tick.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_lat_d = col_lat_q;
    deb_d     = deb_q;
    rel_d     = rel_q;
`ifdef KEY_REPEAT_EN
    rep_d     = rep_q;
`endif
    emit      = 1'b0;

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (col_one_low) begin
            col_lat_d = col_sync_q;
            deb_d     = '0;
            state_d   = StDebounce;
          end else begin
            // No key, or ghosting/multi-key: keep scanning.
            row_d = row_rot;
          end
        end

        StDebounce: begin
          if (col_sync_q == col_lat_q) begin
            deb_d = deb_q + 1'b1;
            if (deb_done) begin
              state_d = StPressed;
              rel_d   = '0;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
              emit    = 1'b1;
            end
          end else begin
            state_d = StScan;
            row_d   = row_rot;
          end
        end

        StPressed: begin
          if (col_all_high) begin
`ifdef KEY_REPEAT_EN
            rep_d = '0;
`endif
            if (rel_q == DebLast) begin
              state_d = StScan;
              row_d   = row_rot;
              rel_d   = '0;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end else begin
            // Any low column, including a second key, just restarts the release count.
            rel_d = '0;
`ifdef KEY_REPEAT_EN
            if (rep_q == RepLast) begin
              rep_d = '0;
              emit  = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end

        default: begin
          state_d = StScan;
          row_d   = 4'b1110;
        end
      endcase
    end
  end

  // Output logic. Code and BCD register with the pulse, so they are valid with it.
  always_comb begin
    ev_code     = map_key(low_idx(row_q), low_idx(col_lat_q));
    key_valid_d = emit;
    key_code_d  = key_code_q;
    bcd_d       = bcd_q;
    if (emit) begin
      key_code_d = ev_code;
      if (ev_code <= 4'd9) begin
        bcd_d = {bcd_q[3:0], ev_code};
      end else if (ev_code == 4'hC) begin
        bcd_d = 8'h00;
      end
    end
  end

  assign row_out   = row_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner. It uses SCAN_DIV=4, DEBOUNCE_SCANS=2
// and REPEAT_SCANS=5. A keypad model drives col_in from row_out and the
// simulated key.

`timescale 1ns/1ps

module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] bcd_out;

  int n_chk = 0;
  int n_err = 0;
  int ev_cnt = 0;

  logic       key_down;
  logic       ghost;
  logic [1:0] key_r;
  logic [1:0] key_c;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2),
    .REPEAT_SCANS  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .bcd_out  (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed switch shorts its column to its row.
  always_comb begin
    col_in = 4'hF;
    if (key_down && (row_out[key_r] == 1'b0)) col_in[key_c] = 1'b0;
    if (ghost && (row_out[0] == 1'b0)) col_in = 4'b1100;
  end

  always @(negedge clk) if (key_valid) ev_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_event(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_row_change(output int cyc);
    logic [3:0] r0;
    r0  = row_out;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (row_out == r0 && cyc < 50);
  endtask

  // Stop at the first negedge after row_out has just switched to the given pattern.
  task automatic wait_fresh_row(input logic [3:0] pat, output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = row_out;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (row_out == pat && prev != pat) begin
        ok = 1'b1;
        break;
      end
      prev = row_out;
    end
  endtask

  // Press a key until it is accepted, then release it at once. The scan must
  // hold the row for exactly two release ticks.
  task automatic press_release(input string tag, input logic [1:0] r, input logic [1:0] c,
                               input logic [3:0] exp_code, input logic [7:0] exp_bcd);
    int         base;
    bit         seen;
    logic [1:0] rn;
    logic [3:0] exp_row;
    logic [3:0] exp_next;
    base     = ev_cnt;
    rn       = r + 2'd1;
    exp_row  = ~(4'b0001 << r);
    exp_next = ~(4'b0001 << rn);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    wait_event(300, seen);
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_code"}, 32'(key_code), 32'(exp_code));
    check_eq({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    key_down = 1'b0;
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(key_valid), 32'd0);
    repeat (6) @(negedge clk);
    check_eq({tag, "_held"}, 32'(row_out), 32'(exp_row));
    @(negedge clk);
    check_eq({tag, "_resume"}, 32'(row_out), 32'(exp_next));
    repeat (8) @(negedge clk);
    check_eq({tag, "_count"}, ev_cnt - base, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  base;
    int  changes;
    bit  ok;
    bit  seen;
    logic [3:0] prev;

    rst_n    = 1'b0;
    key_down = 1'b0;
    ghost    = 1'b0;
    key_r    = 2'd0;
    key_c    = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_row", 32'(row_out), 32'hE);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_code", 32'(key_code), 32'd0);
    check_eq("rst_bcd", 32'(bcd_out), 32'h00);
    rst_n = 1'b1;

    // Idle scan: one row step every 4 clocks
    wait_row_change(cyc);
    check_eq("scan_step1_cyc", cyc, 32'd4);
    check_eq("scan_step1_row", 32'(row_out), 32'hD);
    wait_row_change(cyc);
    check_eq("scan_step2_cyc", cyc, 32'd4);
    check_eq("scan_step2_row", 32'(row_out), 32'hB);
    wait_row_change(cyc);
    check_eq("scan_step3_row", 32'(row_out), 32'h7);
    wait_row_change(cyc);
    check_eq("scan_wrap_row", 32'(row_out), 32'hE);
    check_eq("scan_no_event", ev_cnt, 32'd0);
    check_eq("scan_bcd", 32'(bcd_out), 32'h00);

    press_release("k7", 2'd2, 2'd0, 4'h7, 8'h07);
    press_release("kc", 2'd2, 2'd3, 4'hC, 8'h00);
    press_release("k4", 2'd1, 2'd0, 4'h4, 8'h04);
    press_release("k2", 2'd0, 2'd1, 4'h2, 8'h42);
    press_release("ka", 2'd0, 2'd3, 4'hA, 8'h42);
    press_release("k0", 2'd3, 2'd1, 4'h0, 8'h20);

    // Bounce: low for the detect tick, high on the next tick, then stable
    wait_fresh_row(4'hE, ok);
    check_eq("bounce_align", 32'(ok), 32'd1);
    base     = ev_cnt;
    key_r    = 2'd0;
    key_c    = 2'd0;
    key_down = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("bounce_detect_hold", 32'(row_out), 32'hE);
    key_down = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("bounce_abort_row", 32'(row_out), 32'hD);
    check_eq("bounce_no_event", ev_cnt - base, 32'd0);
    press_release("k1", 2'd0, 2'd0, 4'h1, 8'h01);

    // Two columns low on row0: ignored, scan keeps rotating
    ghost   = 1'b1;
    base    = ev_cnt;
    changes = 0;
    prev    = row_out;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (row_out != prev) changes++;
      prev = row_out;
    end
    check_eq("ghost_rotations", changes, 32'd16);
    check_eq("ghost_no_event", ev_cnt - base, 32'd0);
    ghost = 1'b0;

    // Reset while in debounce, key held through reset release
    wait_fresh_row(4'hB, ok);
    check_eq("rstdeb_align", 32'(ok), 32'd1);
    key_r    = 2'd2;
    key_c    = 2'd2;
    key_down = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rstdeb_row_held", 32'(row_out), 32'hB);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rstdeb_row", 32'(row_out), 32'hE);
    check_eq("rstdeb_bcd", 32'(bcd_out), 32'h00);
    check_eq("rstdeb_code", 32'(key_code), 32'h0);
    check_eq("rstdeb_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = ev_cnt;
    repeat (8) @(negedge clk);
    check_eq("rstdeb_no_early_event", ev_cnt - base, 32'd0);
    wait_event(300, seen);
    check_eq("rstdeb_seen", 32'(seen), 32'd1);
    check_eq("rstdeb_k9_code", 32'(key_code), 32'h9);
    check_eq("rstdeb_k9_bcd", 32'(bcd_out), 32'h09);
    key_down = 1'b0;
    repeat (20) @(negedge clk);

    press_release("kc2", 2'd2, 2'd3, 4'hC, 8'h00);

    // Hold "5" for 15 ticks after acceptance
    base     = ev_cnt;
    key_r    = 2'd1;
    key_c    = 2'd1;
    key_down = 1'b1;
    wait_event(300, seen);
    check_eq("hold5_seen", 32'(seen), 32'd1);
    check_eq("hold5_code", 32'(key_code), 32'h5);
    repeat (63) @(negedge clk);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
`ifdef KEY_REPEAT_EN
    check_eq("hold5_events", ev_cnt - base, 32'd4);
    check_eq("hold5_bcd", 32'(bcd_out), 32'h55);
`else
    check_eq("hold5_events", ev_cnt - base, 32'd1);
    check_eq("hold5_bcd", 32'(bcd_out), 32'h05);
`endif
    check_eq("hold5_final_code", 32'(key_code), 32'h5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
